// File: rtl/sha256_stream_core.sv
// SHA-256 compression engine: one 512-bit block per pass, UNROLL rounds per clock,
// with on-chip chaining state (IV, last digest, previous chaining value or external midstate).
module sha256_stream_core #(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   in_mode,
  input  logic [511:0] in_block,
  input  logic [255:0] in_midstate,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_digest
);

  generate
    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8 ||
          UNROLL == 16 || UNROLL == 32 || UNROLL == 64)) begin : g_bad_unroll
      $error("UNROLL must be one of 1, 2, 4, 8, 16, 32, 64");
    end
  endgenerate

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [5:0] RC_LAST = 6'(64 - UNROLL);
  localparam logic [5:0] RC_STEP = 6'(UNROLL % 64);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  state_t         state_reg, state_next;
  logic [5:0]     rc_reg;
  logic [31:0]    work_reg [8];
  logic [31:0]    w_reg [16];
  logic [255:0]   chain_reg;
  logic [255:0]   last_digest_reg;
  logic [255:0]   prev_chain_reg;
  logic [255:0]   out_digest_reg;
  logic           out_valid_reg;

  logic           accept;
  logic           step;
  logic           load_out;
  logic           from_rounds;
  logic [255:0]   init_sel;
  logic [255:0]   digest_next;
  logic [31:0]    w_ext [16+UNROLL];
  logic [31:0]    round_out [8];

  always_comb begin
    case (in_mode)
      2'd0:    init_sel = IV;
      2'd1:    init_sel = last_digest_reg;
      2'd2:    init_sel = prev_chain_reg;
      default: init_sel = in_midstate;
    endcase
  end

  // Schedule words for this cycle's rounds plus the next 16-word window.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      w_ext[i] = w_reg[i];
    end
    for (int i = 16; i < 16 + UNROLL; i++) begin
      w_ext[i] = ssig1(w_ext[i-2]) + w_ext[i-7] + ssig0(w_ext[i-15]) + w_ext[i-16];
    end
  end

  always_comb begin : p_rounds
    logic [31:0] v [8];
    logic [31:0] t1;
    logic [31:0] t2;
    for (int i = 0; i < 8; i++) begin
      v[i] = work_reg[i];
    end
    t1 = '0;
    t2 = '0;
    for (int j = 0; j < UNROLL; j++) begin
      t1 = v[7] + bsig1(v[4]) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[rc_reg + 6'(j)] + w_ext[j];
      t2 = bsig0(v[0]) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6];
      v[6] = v[5];
      v[5] = v[4];
      v[4] = v[3] + t1;
      v[3] = v[2];
      v[2] = v[1];
      v[1] = v[0];
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) begin
      round_out[i] = v[i];
    end
  end

  // Feed-forward: rounds result on a direct finish, frozen working set on HOLD exit.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_feed_forward
      assign digest_next[255-32*gi -: 32] = chain_reg[255-32*gi -: 32] +
                                            (from_rounds ? round_out[gi] : work_reg[gi]);
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    accept      = 1'b0;
    step        = 1'b0;
    load_out    = 1'b0;
    from_rounds = 1'b0;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (rc_reg == RC_LAST) begin
          if (!out_valid_reg || out_ready) begin
            load_out    = 1'b1;
            from_rounds = 1'b1;
            state_next  = IDLE;
          end else begin
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          load_out   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rc_reg          <= '0;
      chain_reg       <= '0;
      last_digest_reg <= IV;
      prev_chain_reg  <= IV;
      out_digest_reg  <= '0;
      out_valid_reg   <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        work_reg[i] <= '0;
      end
      for (int i = 0; i < 16; i++) begin
        w_reg[i] <= '0;
      end
    end else begin
      if (accept) begin
        rc_reg    <= '0;
        chain_reg <= init_sel;
        for (int i = 0; i < 8; i++) begin
          work_reg[i] <= init_sel[255-32*i -: 32];
        end
        for (int i = 0; i < 16; i++) begin
          w_reg[i] <= in_block[511-32*i -: 32];
        end
      end else if (step) begin
        rc_reg <= (rc_reg == RC_LAST) ? 6'd0 : rc_reg + RC_STEP;
        for (int i = 0; i < 8; i++) begin
          work_reg[i] <= round_out[i];
        end
        for (int i = 0; i < 16; i++) begin
          w_reg[i] <= w_ext[i+UNROLL];
        end
      end

      if (load_out) begin
        out_digest_reg  <= digest_next;
        out_valid_reg   <= 1'b1;
        last_digest_reg <= digest_next;
        prev_chain_reg  <= chain_reg;
      end else if (out_valid_reg && out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign in_ready   = (state_reg == IDLE);
  assign out_valid  = out_valid_reg;
  assign out_digest = out_digest_reg;

endmodule

// File: doc/sha256_stream_core.md
# sha256_stream_core

Multi-cycle SHA-256 compression engine with a parametrised round-unroll factor, valid/ready handshakes on both sides and four chaining modes per block: new message, continue, redo and external midstate. It processes one 512-bit block at a time, keeps its own chaining state across blocks and holds each digest until the downstream side accepts it. It sits between a block/padding front end and a digest consumer, such as a comparator or a nonce search loop.

## Interface
- UNROLL, 1, SHA-256 rounds evaluated per clock. Legal values are 1, 2, 4, 8, 16, 32, 64; any other value is an elaboration error.
- clk  in  1  Clock.
- reset  in  1  Asynchronous, active-low reset.
- in_valid  in  1  Block offered.
- in_ready  out  1  Core can accept a block.
- in_mode  in  2  0 = new message (use IV), 1 = continue (use last digest), 2 = redo (use the chaining value of the last completed block), 3 = midstate (use in_midstate).
- in_block  in  512  Message block. W0 = in_block[511:480] … W15 = in_block[31:0].
- in_midstate  in  256  Chaining input for mode 3. H0 = [255:224].
- out_valid  out  1  Digest available.
- out_ready  in  1  Consumer accepts the digest.
- out_digest  out  256  H0 = [255:224] … H7 = [31:0].

## Operation
- N = 64/UNROLL compute cycles per block.
- State machine, reset state IDLE:
  - IDLE: in_ready = 1. On in_valid & in_ready, go to RUN.
  - RUN: round counter rc advances by UNROLL each cycle, from 0 to 64-UNROLL. On the cycle where rc = 64-UNROLL:
    - If the output register is free (out_valid = 0 or out_ready = 1), go to IDLE.
    - Otherwise go to HOLD.
  - HOLD: in_ready = 0 and the rounds are frozen. When out_ready = 1, go to IDLE.
- On block acceptance:
  - chain_reg <= selected init value, chosen by in_mode (IV, last_digest, prev_chain, or in_midstate).
  - Working registers a..h <= the same init value.
  - Schedule window <= in_block.
- Each RUN cycle:
  - Performs rounds rc .. rc+UNROLL-1 combinationally, with Kt drawn from a 64-entry constant table indexed by round.
  - The 16-word Wt window shifts by UNROLL words. New words are computed as σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16].
- Completion, on the final RUN cycle or on HOLD exit:
  - Feed-forward digest D = chain_reg + final a..h, per word mod 2^32.
  - out_digest <= D, out_valid <= 1.
  - last_digest <= D, prev_chain <= chain_reg.
- Output register: out_valid clears on out_valid & out_ready, unless a new digest loads in the same cycle, in which case out_valid stays 1 and the new D replaces the old one.
- Modes 1 and 2 work even when no block has completed since reset; they then use the reset values below.
- All arithmetic is 32-bit, wrap-around modulo 2^32.

## Timing
- Reset values:
  - in_ready = 1 (IDLE), out_valid = 0, out_digest = 0.
  - last_digest = IV and prev_chain = IV.
  - rc = 0, working and schedule registers 0.
- Latency: acceptance on clock edge E0 gives out_valid = 1 after edge E0+N (64 cycles for UNROLL=1, 1 cycle for UNROLL=64), provided out_ready was not blocking.
- Throughput: at most one block per N+1 cycles. in_ready is high in the cycle after completion.
- in_ready is 0 during RUN and HOLD. Once out_valid is high, out_digest stays stable until out_ready.
- Simultaneous events:
  - in_valid may be asserted in the same cycle that out_ready drains the previous digest; both take effect.
  - A block accepted while out_valid = 1 is legal; it only stalls in HOLD if the old digest is still unconsumed at completion.
- Reset mid-RUN or mid-HOLD: the block is aborted and all registers return to reset values. No digest is emitted.

## Test plan
- "abc", new mode (block 61626380_00…00_00000018), UNROLL=1 → out_valid exactly 64 cycles after acceptance. Digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad. Repeat for UNROLL=4 and 64, expecting latency 16 and 1 respectively.
- Two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq": block 1 in mode 0, padding block in mode 1 → second digest 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- Redo: "abc" block in mode 0, then empty-string block (80000000, 0…0) in mode 2 → e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Midstate: in_midstate = IV (6a09e667…5be0cd19), "abc" block in mode 3 → same digest as the first test.
- Backpressure: hold out_ready = 0 across two blocks → second block stalls in HOLD, in_ready stays 0, out_digest holds the first digest. Raising out_ready for one cycle loads the second digest the same cycle, with out_valid staying 1.
- Reset asserted at rc = 20 → out_valid = 0 and in_ready = 1 immediately. A following mode-1 "abc" block yields ba7816bf… because last_digest has reset to IV.
